// File: rtl/gb_bus_pkg.sv
// ----------------------------------------------------------------------------
// gb_bus_pkg
//   Shared types, address map constants and the address decoder for the CPU
//   memory bus responder.
//
//   Contents:
//     region_t       : decoded target region of a request
//     resp_state_t   : responder FSM state (exported for debug)
//     HRAM_BASE, IE_ADDR, HOLE_LO/HI, MBC_LO/HI : address map constants
//     T_SAMPLE       : T-state on which CPU requests are sampled
//     decode_region(): combinational address decode
//     hram_index()   : HRAM word index from a CPU address
//
//   Build option: MBC1_BANKING_EN (define to decode 2000-3FFF writes as the
//   internal ROM bank register instead of forwarding them externally).
// ----------------------------------------------------------------------------
package gb_bus_pkg;

  typedef enum logic [2:0] {
    REG_HRAM,
    REG_IE,
    REG_HOLE,
    REG_EXT,
    REG_MBC
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESP,
    ST_EXT_WAIT
  } resp_state_t;

  localparam logic [15:0] HRAM_BASE = 16'hFF80;
  localparam logic [15:0] IE_ADDR   = 16'hFFFF;
  localparam logic [15:0] HOLE_LO   = 16'hFEA0;
  localparam logic [15:0] HOLE_HI   = 16'hFEFF;
  localparam logic [15:0] MBC_LO    = 16'h2000;
  localparam logic [15:0] MBC_HI    = 16'h3FFF;

  localparam logic [1:0]  T_SAMPLE  = 2'b10;

`ifdef MBC1_BANKING_EN
  localparam bit MBC_EN = 1'b1;
`else
  localparam bit MBC_EN = 1'b0;
`endif

  // Priority matters: FFFF sits above the HRAM window and must win over it.
  // The bank register only claims writes; reads of 2000-3FFF are ROM reads.
  function automatic region_t decode_region(input logic [15:0] addr,
                                            input logic        is_write);
    region_t r;
    r = REG_EXT;
    if (addr == IE_ADDR) begin
      r = REG_IE;
    end else if (addr >= HRAM_BASE) begin
      r = REG_HRAM;
    end else if ((addr >= HOLE_LO) && (addr <= HOLE_HI)) begin
      r = REG_HOLE;
    end else if (MBC_EN && is_write && (addr >= MBC_LO) && (addr <= MBC_HI)) begin
      r = REG_MBC;
    end
    return r;
  endfunction

  // HRAM_BASE is 128-byte aligned, so addr - HRAM_BASE is just the low bits.
  function automatic logic [6:0] hram_index(input logic [15:0] addr);
    return addr[6:0];
  endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// ----------------------------------------------------------------------------
// mem_bus_responder_if
//   CPU-side memory bus between the CPU core (master) and the responder
//   (slave).
//
//   Signals:
//     t_cycle     : CPU T-state; a request is taken when t_cycle == T_SAMPLE
//     addr        : 16-bit address
//     rd, wr      : request strobes (both high counts as a write)
//     wdata       : write data
//     rdata       : read data, valid when rdata_valid
//     rdata_valid : one-cycle completion pulse for reads and writes
//     hold        : responder busy / CPU stall
//
//   Handshake: a request is "valid" on a clock edge where t_cycle == T_SAMPLE
//   and (rd | wr); the responder is "ready" when hold is low. A request is
//   accepted only on an edge where it is valid and the responder is ready.
//   hold rises on the accepting edge and stays high through the cycle in
//   which rdata_valid pulses; anything presented while hold is high is
//   dropped, not queued.
// ----------------------------------------------------------------------------
interface mem_bus_responder_if;
  logic [1:0]  t_cycle;
  logic [15:0] addr;
  logic        rd;
  logic        wr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic        hold;

  modport master (
    output t_cycle, addr, rd, wr, wdata,
    input  rdata, rdata_valid, hold
  );

  modport slave (
    input  t_cycle, addr, rd, wr, wdata,
    output rdata, rdata_valid, hold
  );
endinterface

// File: rtl/mem_bus_responder_hram_array.sv
// ----------------------------------------------------------------------------
// hram_array
//   Single-port synchronous RAM backing the high RAM window. Contents are
//   not reset.
//
//   Ports:
//     clk   : clock
//     we    : write enable (write on rising edge)
//     re    : read enable (q updates on rising edge, 1-cycle latency)
//     addr  : word index
//     wdata : write data
//     q     : registered read data, held when re is low
// ----------------------------------------------------------------------------
module hram_array #(
  parameter int DEPTH = 127,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    q
);

  logic [7:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// ----------------------------------------------------------------------------
// mem_bus_responder
//   Target end of the CPU memory bus. Serves HRAM (FF80-FFFE), the IE
//   register (FFFF) and the unusable hole (FEA0-FEFF) internally with one
//   cycle of latency; everything else goes out on the external port, which
//   holds ext_req for EXT_WAIT+1 cycles and samples ext_rdata on the last.
//
//   Parameters:
//     EXT_WAIT   : external wait count, 0..15
//     HRAM_DEPTH : HRAM bytes (base FF80)
//
//   Ports:
//     clk, rst    : clock, asynchronous active-low reset
//     bus         : CPU bus (slave modport of mem_bus_responder_if)
//     ie_out      : interrupt-enable register
//     ext_req     : external access request, high through the wait count
//     ext_we      : external write qualifier (valid with ext_req)
//     ext_addr    : registered request address
//     ext_wdata   : registered request write data
//     ext_rdata   : external read data
//     ext_bank    : ROM bank for 4000-7FFF
//     state_dbg   : current FSM state
//
//   Build option: MBC1_BANKING_EN -- when defined, writes to 2000-3FFF are
//   consumed internally and load ext_bank (0 maps to 1); otherwise ext_bank
//   is fixed at 1 and those writes are forwarded externally.
// ----------------------------------------------------------------------------
module mem_bus_responder
  import gb_bus_pkg::*;
#(
  parameter int EXT_WAIT   = 2,
  parameter int HRAM_DEPTH = 127
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_responder_if.slave  bus,
  output logic [7:0]          ie_out,
  output logic                ext_req,
  output logic                ext_we,
  output logic [15:0]         ext_addr,
  output logic [7:0]          ext_wdata,
  input  logic [7:0]          ext_rdata,
  output logic [4:0]          ext_bank,
  output resp_state_t         state_dbg
);

  localparam logic [3:0] WAIT_LOAD = 4'(EXT_WAIT);

  resp_state_t state;
  resp_state_t state_d;
  region_t     req_region;
  region_t     cur_region;
  logic        accept;
  logic        done;
  logic        lat_wr;
  logic [3:0]  wait_cnt;
  logic [7:0]  hram_q;

  assign req_region = decode_region(bus.addr, bus.wr);

  // hold doubles as "not ready": it stays high through the rdata_valid
  // cycle, so a new request can only land once that pulse is over.
  assign accept = (state == ST_IDLE) && !bus.hold &&
                  (bus.t_cycle == T_SAMPLE) && (bus.rd || bus.wr);

  assign done = (state == ST_RESP) ||
                ((state == ST_EXT_WAIT) && (wait_cnt == 4'd0));

  assign state_dbg = state;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d = (req_region == REG_EXT) ? ST_EXT_WAIT : ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      ST_EXT_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // HRAM: the array is addressed straight from the bus on the accepting
  // edge so the read data is already in hram_q when RESP completes.
  // --------------------------------------------------------------------------
  hram_array #(
    .DEPTH (HRAM_DEPTH),
    .AW    (7)
  ) u_hram (
    .clk   (clk),
    .we    (accept && (req_region == REG_HRAM) && bus.wr),
    .re    (accept && (req_region == REG_HRAM) && !bus.wr),
    .addr  (hram_index(bus.addr)),
    .wdata (bus.wdata),
    .q     (hram_q)
  );

  // --------------------------------------------------------------------------
  // Request latch, external port, response path
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rdata       <= 8'hFF;
      bus.rdata_valid <= 1'b0;
      bus.hold        <= 1'b0;
      ext_req         <= 1'b0;
      ext_we          <= 1'b0;
      ext_addr        <= 16'h0000;
      ext_wdata       <= 8'h00;
      ie_out          <= 8'h00;
      wait_cnt        <= 4'd0;
      lat_wr          <= 1'b0;
      cur_region      <= REG_EXT;
    end else begin
      bus.rdata_valid <= done;

      if (accept) begin
        bus.hold   <= 1'b1;
        ext_addr   <= bus.addr;
        ext_wdata  <= bus.wdata;
        lat_wr     <= bus.wr;
        cur_region <= req_region;
        wait_cnt   <= WAIT_LOAD;
        if (req_region == REG_EXT) begin
          ext_req <= 1'b1;
          ext_we  <= bus.wr;
        end
      end else if (bus.rdata_valid) begin
        bus.hold <= 1'b0;
      end

      if ((state == ST_EXT_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (done) begin
        ext_req <= 1'b0;
        ext_we  <= 1'b0;
        // Writes never touch rdata; it keeps the last read value.
        case (cur_region)
          REG_HRAM: begin
            if (!lat_wr) bus.rdata <= hram_q;
          end
          REG_IE: begin
            if (lat_wr) ie_out <= ext_wdata;
            else        bus.rdata <= ie_out;
          end
          REG_HOLE: begin
            if (!lat_wr) bus.rdata <= 8'hFF;
          end
          REG_EXT: begin
            if (!lat_wr) bus.rdata <= ext_rdata;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // ROM bank register
  // --------------------------------------------------------------------------
`ifdef MBC1_BANKING_EN
  logic [4:0] bank_q;

  // Bank 0 is not selectable in the 4000-7FFF window; it aliases to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q <= 5'd1;
    end else if (done && (cur_region == REG_MBC)) begin
      bank_q <= (ext_wdata[4:0] == 5'd0) ? 5'd1 : ext_wdata[4:0];
    end
  end

  assign ext_bank = bank_q;
`else
  assign ext_bank = 5'd1;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_responder
//   Bench for mem_bus_responder. Two instances share stimulus: dut uses
//   EXT_WAIT=2, dut0 uses EXT_WAIT=0 and is only checked for its latency.
// ----------------------------------------------------------------------------
module tb_mem_bus_responder;
  import gb_bus_pkg::*;

  localparam int EXT_W   = 2;
  localparam int LAT_EXT = EXT_W + 1;

`ifdef MBC1_BANKING_EN
  localparam bit MBC_ON = 1'b1;
`else
  localparam bit MBC_ON = 1'b0;
`endif
  localparam int         LAT_MBC = MBC_ON ? 1 : LAT_EXT;
  localparam int         EXT_MBC = MBC_ON ? 0 : LAT_EXT;
  localparam logic [4:0] BANK13  = MBC_ON ? 5'h13 : 5'd1;

  // --------------------------------------------------------------------------
  // Clock / reset / DUTs
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_bus_responder_if bus ();
  mem_bus_responder_if bus0 ();

  assign bus0.t_cycle = bus.t_cycle;
  assign bus0.addr    = bus.addr;
  assign bus0.rd      = bus.rd;
  assign bus0.wr      = bus.wr;
  assign bus0.wdata   = bus.wdata;

  logic [7:0]  ie_out, ie_out0;
  logic        ext_req, ext_req0, ext_we, ext_we0;
  logic [15:0] ext_addr, ext_addr0;
  logic [7:0]  ext_wdata, ext_wdata0;
  logic [7:0]  ext_rdata;
  logic [4:0]  ext_bank, ext_bank0;
  resp_state_t state_dbg, state_dbg0;

  mem_bus_responder #(.EXT_WAIT(EXT_W), .HRAM_DEPTH(127)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ie_out(ie_out), .ext_req(ext_req),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_bank(ext_bank), .state_dbg(state_dbg)
  );

  mem_bus_responder #(.EXT_WAIT(0), .HRAM_DEPTH(127)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .ie_out(ie_out0), .ext_req(ext_req0),
    .ext_we(ext_we0), .ext_addr(ext_addr0), .ext_wdata(ext_wdata0),
    .ext_rdata(ext_rdata), .ext_bank(ext_bank0), .state_dbg(state_dbg0)
  );

  // --------------------------------------------------------------------------
  // Scoreboard counters and compare
  // --------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: address map applied with plain range tests
  // --------------------------------------------------------------------------
  logic [7:0] m_hram [0:126];
  logic [7:0] m_ie;
  logic [7:0] m_rdata;
  logic [4:0] m_bank;

  task automatic model_reset();
    m_ie    = 8'h00;
    m_rdata = 8'hFF;
    m_bank  = 5'd1;
  endtask

  task automatic model_txn(input logic [15:0] a, input logic r, input logic w,
                           input logic [7:0] d, input logic [7:0] xd,
                           output int e_lat, output int e_ext);
    int a_i;
    a_i   = int'(a);
    e_lat = 1;
    e_ext = 0;
    if (!(r || w)) return;
    if (a_i == 'hFFFF) begin
      if (w) m_ie = d; else m_rdata = m_ie;
    end else if (a_i >= 'hFF80) begin
      if (w) m_hram[a_i - 'hFF80] = d; else m_rdata = m_hram[a_i - 'hFF80];
    end else if (a_i >= 'hFEA0 && a_i <= 'hFEFF) begin
      if (!w) m_rdata = 8'hFF;
    end else if (MBC_ON && w && a_i >= 'h2000 && a_i <= 'h3FFF) begin
      m_bank = (d[4:0] == 5'd0) ? 5'd1 : d[4:0];
    end else begin
      e_lat = EXT_W + 1;
      e_ext = EXT_W + 1;
      if (!w) m_rdata = xd;
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver: one request presented for one T2 edge, then observe until done
  // --------------------------------------------------------------------------
  task automatic bus_idle();
    bus.t_cycle = 2'b11;
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
  endtask

  task automatic run_txn(input logic [15:0] a, input logic r, input logic w,
                         input logic [7:0] d, input logic [7:0] xd,
                         output int lat, output int lat0, output int ext_cyc,
                         output bit hold_ok, output bit ctrl_ok, output bit post_ok);
    lat = -1; lat0 = -1; ext_cyc = 0; hold_ok = 1'b1; ctrl_ok = 1'b1; post_ok = 1'b0;
    @(negedge clk);
    bus.t_cycle = T_SAMPLE;
    bus.addr    = a;
    bus.rd      = r;
    bus.wr      = w;
    bus.wdata   = d;
    ext_rdata   = xd;
    @(negedge clk);
    bus_idle();
    for (int k = 1; k < 40; k++) begin
      if (ext_req) begin
        ext_cyc++;
        if (ext_we !== w || ext_addr !== a || (w && ext_wdata !== d)) ctrl_ok = 1'b0;
      end
      if (bus.hold !== 1'b1) hold_ok = 1'b0;
      if (lat0 < 0 && bus0.rdata_valid === 1'b1) lat0 = k - 1;
      if (bus.rdata_valid === 1'b1) begin
        lat = k - 1;
        break;
      end
      @(negedge clk);
    end
    if (lat >= 0) begin
      @(negedge clk);
      post_ok = (bus.rdata_valid === 1'b0) && (bus.hold === 1'b0);
    end
  endtask

  task automatic do_and_check(input string tag, input logic [15:0] a, input logic r,
                              input logic w, input logic [7:0] d, input logic [7:0] xd,
                              input logic [7:0] e_rdata, input logic [7:0] e_ie,
                              input logic [4:0] e_bank, input int e_lat, input int e_ext);
    int lat, lat0, ext_cyc;
    bit hold_ok, ctrl_ok, post_ok;
    run_txn(a, r, w, d, xd, lat, lat0, ext_cyc, hold_ok, ctrl_ok, post_ok);
    check({tag, " latency"}, lat, e_lat);
    check({tag, " ext_req cycles"}, ext_cyc, e_ext);
    check({tag, " latency wait0"}, lat0, 1);
    check({tag, " hold during access"}, 32'(hold_ok), 1);
    check({tag, " ext_we/addr/wdata"}, 32'(ctrl_ok), 1);
    check({tag, " single pulse, hold drop"}, 32'(post_ok), 1);
    check({tag, " rdata"}, bus.rdata, e_rdata);
    check({tag, " ie_out"}, ie_out, e_ie);
    check({tag, " ext_bank"}, ext_bank, e_bank);
  endtask

  // --------------------------------------------------------------------------
  // Directed vectors
  // --------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [7:0]  wdata;
    logic [7:0]  xdata;
    logic [7:0]  exp_rdata;
    logic [7:0]  exp_ie;
    logic [4:0]  exp_bank;
    int          exp_lat;
    int          exp_ext;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int         e_lat, e_ext, vcnt, xcnt, xrise;
    logic       prev_req;
    logic [15:0] a;
    logic       r, w;
    logic [7:0] d, xd;

    bus.t_cycle = 2'b00; bus.addr = 16'h0000; bus.rd = 1'b0; bus.wr = 1'b0;
    bus.wdata = 8'h00; ext_rdata = 8'h00;
    model_reset();

    vecs.push_back('{"wr hram FF80",  16'hFF80, 1'b0, 1'b1, 8'h5A, 8'h00, 8'hFF, 8'h00, 5'd1, 1, 0});
    vecs.push_back('{"rd hram FF80",  16'hFF80, 1'b1, 1'b0, 8'h00, 8'h00, 8'h5A, 8'h00, 5'd1, 1, 0});
    vecs.push_back('{"wr ie",         16'hFFFF, 1'b0, 1'b1, 8'h1F, 8'h00, 8'h5A, 8'h1F, 5'd1, 1, 0});
    vecs.push_back('{"rd ie",         16'hFFFF, 1'b1, 1'b0, 8'h00, 8'h00, 8'h1F, 8'h1F, 5'd1, 1, 0});
    vecs.push_back('{"rd hole FEC0",  16'hFEC0, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h1F, 5'd1, 1, 0});
    vecs.push_back('{"wr hole FEA0",  16'hFEA0, 1'b0, 1'b1, 8'h33, 8'h00, 8'hFF, 8'h1F, 5'd1, 1, 0});
    vecs.push_back('{"wr hram FFFE",  16'hFFFE, 1'b0, 1'b1, 8'hC3, 8'h00, 8'hFF, 8'h1F, 5'd1, 1, 0});
    vecs.push_back('{"rd hram FFFE",  16'hFFFE, 1'b1, 1'b0, 8'h00, 8'h00, 8'hC3, 8'h1F, 5'd1, 1, 0});
    vecs.push_back('{"rd ext C000",   16'hC000, 1'b1, 1'b0, 8'h00, 8'hA5, 8'hA5, 8'h1F, 5'd1, LAT_EXT, LAT_EXT});
    vecs.push_back('{"wr ext C123",   16'hC123, 1'b0, 1'b1, 8'h77, 8'h11, 8'hA5, 8'h1F, 5'd1, LAT_EXT, LAT_EXT});
    vecs.push_back('{"rd ext FE9F",   16'hFE9F, 1'b1, 1'b0, 8'h00, 8'h42, 8'h42, 8'h1F, 5'd1, LAT_EXT, LAT_EXT});
    vecs.push_back('{"rd ext FF7F",   16'hFF7F, 1'b1, 1'b0, 8'h00, 8'h24, 8'h24, 8'h1F, 5'd1, LAT_EXT, LAT_EXT});
    vecs.push_back('{"rdwr hram FF81",16'hFF81, 1'b1, 1'b1, 8'h99, 8'h00, 8'h24, 8'h1F, 5'd1, 1, 0});
    vecs.push_back('{"rd hram FF81",  16'hFF81, 1'b1, 1'b0, 8'h00, 8'h00, 8'h99, 8'h1F, 5'd1, 1, 0});
    vecs.push_back('{"wr bank 00",    16'h2100, 1'b0, 1'b1, 8'h00, 8'h00, 8'h99, 8'h1F, 5'd1, LAT_MBC, EXT_MBC});
    vecs.push_back('{"wr bank 13",    16'h2100, 1'b0, 1'b1, 8'h13, 8'h00, 8'h99, 8'h1F, BANK13, LAT_MBC, EXT_MBC});
    vecs.push_back('{"rd rom 3000",   16'h3000, 1'b1, 1'b0, 8'h00, 8'h6E, 8'h6E, 8'h1F, BANK13, LAT_EXT, LAT_EXT});

    // ---------------- reset values ----------------
    repeat (3) @(negedge clk);
    check("reset rdata", bus.rdata, 8'hFF);
    check("reset rdata_valid", bus.rdata_valid, 0);
    check("reset hold", bus.hold, 0);
    check("reset ext_req", ext_req, 0);
    check("reset ext_we", ext_we, 0);
    check("reset ext_addr", ext_addr, 0);
    check("reset ext_wdata", ext_wdata, 0);
    check("reset ie_out", ie_out, 0);
    check("reset ext_bank", ext_bank, 1);
    check("reset state", 32'(state_dbg), 32'(ST_IDLE));
    bus_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- directed table ----------------
    foreach (vecs[i]) begin
      model_txn(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, vecs[i].xdata, e_lat, e_ext);
      do_and_check(vecs[i].name, vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata,
                   vecs[i].xdata, vecs[i].exp_rdata, vecs[i].exp_ie, vecs[i].exp_bank,
                   vecs[i].exp_lat, vecs[i].exp_ext);
    end

    // ---------------- reset in the middle of an external access ----------------
    @(negedge clk);
    bus.t_cycle = T_SAMPLE; bus.addr = 16'hC000; bus.rd = 1'b1; bus.wr = 1'b0; ext_rdata = 8'h3C;
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    check("midreset ext_req before", ext_req, 1);
    rst = 1'b0;
    #1;
    check("midreset ext_req", ext_req, 0);
    check("midreset hold", bus.hold, 0);
    check("midreset rdata", bus.rdata, 8'hFF);
    check("midreset ie_out", ie_out, 8'h00);
    check("midreset ext_bank", ext_bank, 5'd1);
    check("midreset state", 32'(state_dbg), 32'(ST_IDLE));
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    vcnt = 0; xcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rdata_valid === 1'b1) vcnt++;
      if (ext_req === 1'b1) xcnt++;
    end
    check("midreset no valid pulse", vcnt, 0);
    check("midreset no ext_req", xcnt, 0);

    // ---------------- fill HRAM ----------------
    for (int i = 0; i < 127; i++) begin
      a = 16'hFF80 + 16'(i);
      d = 8'($urandom_range(0, 255));
      model_txn(a, 1'b0, 1'b1, d, 8'h00, e_lat, e_ext);
      do_and_check("hram fill", a, 1'b0, 1'b1, d, 8'h00, m_rdata, m_ie, m_bank, e_lat, e_ext);
    end

    // ---------------- busy: second request while hold is high ----------------
    @(negedge clk);
    bus.t_cycle = T_SAMPLE; bus.addr = 16'hC000; bus.rd = 1'b1; bus.wr = 1'b0; ext_rdata = 8'h5C;
    model_txn(16'hC000, 1'b1, 1'b0, 8'h00, 8'h5C, e_lat, e_ext);
    vcnt = 0; xcnt = 0; xrise = 0; prev_req = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.addr = 16'hFF90; bus.rd = 1'b0; bus.wr = 1'b1; bus.wdata = 8'hEE;
      end
      if (k == 5) bus_idle();
      if (bus.rdata_valid === 1'b1) vcnt++;
      if (ext_req === 1'b1) xcnt++;
      if (ext_req === 1'b1 && prev_req === 1'b0) xrise++;
      prev_req = ext_req;
    end
    check("busy valid pulses", vcnt, 1);
    check("busy ext_req cycles", xcnt, LAT_EXT);
    check("busy ext_req starts", xrise, 1);
    check("busy rdata", bus.rdata, 8'h5C);
    model_txn(16'hFF90, 1'b1, 1'b0, 8'h00, 8'h00, e_lat, e_ext);
    do_and_check("busy write dropped", 16'hFF90, 1'b1, 1'b0, 8'h00, 8'h00,
                 m_rdata, m_ie, m_bank, e_lat, e_ext);

    // ---------------- strobe outside T2 is not sampled ----------------
    @(negedge clk);
    bus.t_cycle = 2'b01; bus.addr = 16'hFF80; bus.rd = 1'b1; bus.wr = 1'b0;
    @(negedge clk);
    bus_idle();
    check("non-T2 hold", bus.hold, 0);
    @(negedge clk);
    check("non-T2 valid", bus.rdata_valid, 0);
    check("non-T2 rdata", bus.rdata, m_rdata);

    // ---------------- randomized traffic against the model ----------------
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0: a = 16'hFF80 + 16'($urandom_range(0, 126));
        1: a = 16'hFFFF;
        2: a = 16'hFEA0 + 16'($urandom_range(0, 95));
        3: a = 16'h2000 + 16'($urandom_range(0, 16'h1FFF));
        default: a = 16'($urandom_range(0, 16'hFFFF));
      endcase
      case ($urandom_range(0, 2))
        0: begin r = 1'b1; w = 1'b0; end
        1: begin r = 1'b0; w = 1'b1; end
        default: begin r = 1'b1; w = 1'b1; end
      endcase
      d  = 8'($urandom_range(0, 255));
      xd = 8'($urandom_range(0, 255));
      model_txn(a, r, w, d, xd, e_lat, e_ext);
      do_and_check("random", a, r, w, d, xd, m_rdata, m_ie, m_bank, e_lat, e_ext);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
